// File: rtl/instr_mem_pkg.sv
// Shared constants and helpers for the fetch-stage instruction memory.
package instr_mem_pkg;

  localparam logic [31:0] NOP_INSTR = 32'b0;
  localparam int LAT_MIN = 1;
  localparam int LAT_MAX = 2;

  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_pipe_reg.sv
// One fetch pipeline stage {valid, fault, pc, instr}. Stall holds the stage,
// flush kills it, and a bubble clears valid while leaving the payload untouched.
module fetch_pipe_reg
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               vld_d,
  input  logic               fault_d,
  input  logic [ADDR_W-1:0]  pc_d,
  input  logic [INSTR_W-1:0] instr_d,
  output logic               vld_q,
  output logic               fault_q,
  output logic [ADDR_W-1:0]  pc_q,
  output logic [INSTR_W-1:0] instr_q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      fault_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= INSTR_W'(NOP_INSTR);
    end else if (flush) begin
      vld_q <= 1'b0;
    end else if (!stall) begin
      vld_q <= vld_d;
      if (vld_d) begin
        fault_q <= fault_d;
        pc_q    <= pc_d;
        instr_q <= instr_d;
      end
    end
  end

endmodule

// File: rtl/instr_mem_pipe.sv
// Synchronous instruction memory for the fetch stage: registered array read,
// optional extra output stage, stall/flush control, fault tagging and a loader port.
module instr_mem_pipe
  import instr_mem_pkg::*;
#(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32,
  parameter int DEPTH   = 2048,
  parameter int LATENCY = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_i,
  input  logic [ADDR_W-1:0]  pc_addr_i,
  input  logic               stall_i,
  input  logic               flush_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic               valid_o,
  output logic               fault_o,
  output logic [ADDR_W-1:0]  pc_o,
  input  logic               wr_en_i,
  input  logic [ADDR_W-1:0]  wr_addr_i,
  input  logic [INSTR_W-1:0] wr_data_i
);

  localparam int IDX_W = idx_w(DEPTH);
  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_INSTR);

  generate
    if (LATENCY < LAT_MIN || LATENCY > LAT_MAX) begin : g_bad_latency
      $error("instr_mem_pipe: LATENCY must be 1 or 2");
    end
    if ((1 << IDX_W) != DEPTH) begin : g_bad_depth
      $error("instr_mem_pipe: DEPTH must be a power of two");
    end
  endgenerate

  // Misaligned, or word index beyond DEPTH (any set bit above the index field).
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || (a[ADDR_W-1:IDX_W+2] != '0);
  endfunction

  logic [INSTR_W-1:0] mem [0:DEPTH-1] = '{default: '0};

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             rd_fault;
  logic             wr_ok;

  assign rd_idx   = pc_addr_i[IDX_W+1:2];
  assign wr_idx   = wr_addr_i[IDX_W+1:2];
  assign rd_fault = addr_bad(pc_addr_i);
  assign wr_ok    = wr_en_i && !addr_bad(wr_addr_i);

  // Loader write port; runs regardless of stall/flush.
  always_ff @(posedge clk_i) begin
    if (wr_ok) begin
      mem[wr_idx] <= wr_data_i;
    end
  end

  // ---- stage p1: registered array read (old data on same-word write) ----
  logic               vld_p1;
  logic               fault_p1;
  logic [ADDR_W-1:0]  pc_p1;
  logic [INSTR_W-1:0] instr_p1;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      vld_p1   <= 1'b0;
      fault_p1 <= 1'b0;
      pc_p1    <= '0;
      instr_p1 <= NOP;
    end else if (flush_i) begin
      vld_p1 <= 1'b0;
    end else if (!stall_i) begin
      vld_p1 <= req_i;
      if (req_i) begin
        fault_p1 <= rd_fault;
        pc_p1    <= pc_addr_i;
        instr_p1 <= rd_fault ? NOP : mem[rd_idx];
      end
    end
  end

  // ---- stage p2 (LATENCY=2 only): extra output register ----
  generate
    if (LATENCY >= 2) begin : g_lat2
      logic               vld_p2;
      logic               fault_p2;
      logic [ADDR_W-1:0]  pc_p2;
      logic [INSTR_W-1:0] instr_p2;

      fetch_pipe_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
      ) u_stage_p2 (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .stall   (stall_i),
        .flush   (flush_i),
        .vld_d   (vld_p1),
        .fault_d (fault_p1),
        .pc_d    (pc_p1),
        .instr_d (instr_p1),
        .vld_q   (vld_p2),
        .fault_q (fault_p2),
        .pc_q    (pc_p2),
        .instr_q (instr_p2)
      );

      assign valid_o = vld_p2;
      assign fault_o = fault_p2;
      assign pc_o    = pc_p2;
      assign instr_o = instr_p2;
    end else begin : g_lat1
      assign valid_o = vld_p1;
      assign fault_o = fault_p1;
      assign pc_o    = pc_p1;
      assign instr_o = instr_p1;
    end
  endgenerate

endmodule

// File: tb/tb_instr_mem_pipe.sv
// Directed bench: a LATENCY=1 and a LATENCY=2 instance share one stimulus stream.
module tb_instr_mem_pipe;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;
  localparam int DEPTH   = 2048;

  localparam logic [31:0] WA = 32'h0000_000A;
  localparam logic [31:0] WB = 32'h0000_000B;
  localparam logic [31:0] WC = 32'h0000_000C;
  localparam logic [31:0] WD = 32'hDEAD_BEEF;

  logic               clk = 1'b0;
  logic               rst_i = 1'b0;
  logic               req_i = 1'b0;
  logic               stall_i = 1'b0;
  logic               flush_i = 1'b0;
  logic               wr_en_i = 1'b0;
  logic [ADDR_W-1:0]  pc_addr_i = '0;
  logic [ADDR_W-1:0]  wr_addr_i = '0;
  logic [INSTR_W-1:0] wr_data_i = '0;

  logic [INSTR_W-1:0] instr1, instr2;
  logic               valid1, valid2, fault1, fault2;
  logic [ADDR_W-1:0]  pc1, pc2;

  always #5 clk = ~clk;

  instr_mem_pipe #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .LATENCY(1)) u_lat1 (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .pc_addr_i(pc_addr_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .instr_o(instr1), .valid_o(valid1), .fault_o(fault1), .pc_o(pc1),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i)
  );

  instr_mem_pipe #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .LATENCY(2)) u_lat2 (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .pc_addr_i(pc_addr_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .instr_o(instr2), .valid_o(valid2), .fault_o(fault2), .pc_o(pc2),
    .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i), .wr_data_i(wr_data_i)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        fault;
  } vec_t;

  vec_t tbl [7];

  // Stall window (edges 0-8) followed by flush-with-stall window (edges 9-13).
  logic [63:0] sq_pc    [14] = '{64'h0, 64'h4, 64'h8, 64'h8, 64'h8, 64'h8, 64'hC, 64'h0, 64'h0,
                                 64'h0, 64'h4, 64'h8, 64'h0, 64'h0};
  logic        sq_req   [14] = '{1, 1, 1, 1, 1, 1, 1, 0, 0,  1, 1, 1, 0, 0};
  logic        sq_stall [14] = '{0, 0, 1, 1, 1, 0, 0, 0, 0,  0, 0, 1, 0, 0};
  logic        sq_flush [14] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0};
  logic        sq_v1    [14] = '{1, 1, 1, 1, 1, 1, 1, 0, 0,  1, 1, 0, 0, 0};
  logic [31:0] sq_e1    [14] = '{WA, WB, WB, WB, WB, WC, WD, 0, 0,  WA, WB, 0, 0, 0};
  logic        sq_v2    [14] = '{0, 1, 1, 1, 1, 1, 1, 1, 0,  0, 1, 0, 0, 0};
  logic [31:0] sq_e2    [14] = '{0, WA, WA, WA, WA, WB, WC, WD, 0,  0, WA, 0, 0, 0};

  logic [31:0] b2b [3] = '{WA, WB, WC};

  int nvec  = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [63:0] pc, input logic s, input logic f);
    req_i     = r;
    pc_addr_i = pc;
    stall_i   = s;
    flush_i   = f;
  endtask

  task automatic load(input logic [63:0] addr, input logic [31:0] data);
    wr_en_i   = 1'b1;
    wr_addr_i = addr;
    wr_data_i = data;
    tick();
    wr_en_i   = 1'b0;
  endtask

  initial begin
    tbl[0] = '{pc: 64'h0000_0000_0000_000C, instr: WD,    fault: 1'b0};
    tbl[1] = '{pc: 64'h0000_0000_0000_0006, instr: 32'h0, fault: 1'b1};
    tbl[2] = '{pc: 64'h0000_0000_0000_2000, instr: 32'h0, fault: 1'b1};
    tbl[3] = '{pc: 64'h0000_0000_0000_0010, instr: 32'h0, fault: 1'b0};
    tbl[4] = '{pc: 64'h0000_0000_0000_0004, instr: WB,    fault: 1'b0};
    tbl[5] = '{pc: 64'h0000_0000_0000_1FFC, instr: 32'h0, fault: 1'b0};
    tbl[6] = '{pc: 64'h8000_0000_0000_0000, instr: 32'h0, fault: 1'b1};

    // Reset state
    tick();
    tick();
    chk("rst_l1_valid", valid1, 0);
    chk("rst_l1_fault", fault1, 0);
    chk("rst_l1_instr", instr1, 0);
    chk("rst_l1_pc",    pc1,    0);
    chk("rst_l2_valid", valid2, 0);
    chk("rst_l2_instr", instr2, 0);
    @(negedge clk);
    rst_i = 1'b1;
    tick();

    // Program the array; the last two writes are illegal and would alias word 4
    load(64'h0,    WA);
    load(64'h4,    WB);
    load(64'h8,    WC);
    load(64'hC,    WD);
    load(64'h14,   32'h55);
    load(64'h11,   32'hFF);
    load(64'h2010, 32'hEE);

    // Single fetches from the vector table
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, tbl[i].pc, 1'b0, 1'b0);
      tick();
      drive(1'b0, 64'h0, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_l1_valid", i), valid1, 1);
      chk($sformatf("tbl%0d_l1_instr", i), instr1, tbl[i].instr);
      chk($sformatf("tbl%0d_l1_fault", i), fault1, tbl[i].fault);
      chk($sformatf("tbl%0d_l1_pc", i),    pc1,    tbl[i].pc);
      chk($sformatf("tbl%0d_l2_early", i), valid2, 0);
      tick();
      chk($sformatf("tbl%0d_l1_bubble", i), valid1, 0);
      chk($sformatf("tbl%0d_l2_valid", i), valid2, 1);
      chk($sformatf("tbl%0d_l2_instr", i), instr2, tbl[i].instr);
      chk($sformatf("tbl%0d_l2_fault", i), fault2, tbl[i].fault);
      chk($sformatf("tbl%0d_l2_pc", i),    pc2,    tbl[i].pc);
    end

    // Back-to-back fetches of words 0,1,2
    for (int c = 0; c < 5; c++) begin
      if (c < 3) drive(1'b1, 64'(4 * c), 1'b0, 1'b0);
      else       drive(1'b0, 64'h0, 1'b0, 1'b0);
      tick();
      if (c < 3) begin
        chk($sformatf("b2b%0d_l1_valid", c), valid1, 1);
        chk($sformatf("b2b%0d_l1_instr", c), instr1, b2b[c]);
      end
      if (c >= 1 && c < 4) begin
        chk($sformatf("b2b%0d_l2_valid", c), valid2, 1);
        chk($sformatf("b2b%0d_l2_instr", c), instr2, b2b[c-1]);
      end
    end

    // Stall mid-stream, then flush with stall and request in the same cycle
    for (int k = 0; k < 14; k++) begin
      drive(sq_req[k], sq_pc[k], sq_stall[k], sq_flush[k]);
      tick();
      chk($sformatf("seq%0d_l1_valid", k), valid1, sq_v1[k]);
      chk($sformatf("seq%0d_l2_valid", k), valid2, sq_v2[k]);
      if (sq_v1[k]) chk($sformatf("seq%0d_l1_instr", k), instr1, sq_e1[k]);
      if (sq_v2[k]) chk($sformatf("seq%0d_l2_instr", k), instr2, sq_e2[k]);
    end

    // Read and write word 5 in the same cycle: old data first, new on re-read
    drive(1'b1, 64'h14, 1'b0, 1'b0);
    wr_en_i   = 1'b1;
    wr_addr_i = 64'h14;
    wr_data_i = 32'h11;
    tick();
    wr_en_i = 1'b0;
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    chk("rbw_l1_old", instr1, 32'h55);
    tick();
    chk("rbw_l2_old", instr2, 32'h55);
    drive(1'b1, 64'h14, 1'b0, 1'b0);
    tick();
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    chk("rbw_l1_new", instr1, 32'h11);
    tick();
    chk("rbw_l2_new", instr2, 32'h11);

    // Asynchronous reset with a fetch in flight
    drive(1'b1, 64'hC, 1'b0, 1'b0);
    tick();
    drive(1'b0, 64'h0, 1'b0, 1'b0);
    chk("arst_pre_l1_valid", valid1, 1);
    #2;
    rst_i = 1'b0;
    #1;
    chk("arst_l1_valid", valid1, 0);
    chk("arst_l1_instr", instr1, 0);
    chk("arst_l1_pc",    pc1,    0);
    chk("arst_l2_valid", valid2, 0);
    chk("arst_l2_instr", instr2, 0);
    chk("arst_l2_pc",    pc2,    0);
    @(negedge clk);
    rst_i = 1'b1;
    tick();
    tick();
    chk("arst_post_l1_valid", valid1, 0);
    chk("arst_post_l2_valid", valid2, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
